// File: rtl/splitmix256_ctrl.sv
// Sequencer for the four-lane SplitMix mixer: owns the 4x64 generator state, feeds
// the mixer, tracks its latency and buffers results in a credit-protected output FIFO.
// Optional word counter output gen_count is enabled by defining SPLITMIX256_CTRL_COUNT_EN.

module splitmix256_ctrl #(
  parameter int          MIX_LATENCY = 3,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [63:0] GAMMA       = 64'h9E3779B97F4A7C15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_load,
  input  logic [255:0] seed_in,
  output logic         seed_busy,
  input  logic         gen_en,
  output logic [255:0] mix_in,
  input  logic [255:0] mix_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic [1:0]   fsm_state
`ifdef SPLITMIX256_CTRL_COUNT_EN
  ,
  output logic [63:0]  gen_count
`endif
);

  // Output handshake: a word transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid/out_data never depend on out_ready.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MIX_LATENCY + 1);
  localparam int SW = 16;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2
  } fsm_t;

  fsm_t                   fsm_q;
  fsm_t                   fsm_d;
  logic [255:0]           lane_q;
  logic [255:0]           lane_next;
  logic [255:0]           pend_q;
  logic [255:0]           mix_q;
  logic [MIX_LATENCY-1:0] vld_sr;
  logic [IW-1:0]          inflight;
  logic [255:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          fifo_count;
  logic [SW-1:0]          credit_used;
  logic                   credit_ok;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   flush;
  logic                   seed_take;
  logic                   pend_take;

  // Lanes advance independently; the 64-bit adds deliberately drop their carry.
  always_comb begin
    lane_next = '0;
    for (int i = 0; i < 4; i++) begin
      lane_next[i*64 +: 64] = lane_q[i*64 +: 64] + GAMMA;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MIX_LATENCY; i++) begin
      inflight = inflight + IW'(vld_sr[i]);
    end
  end

  assign push      = vld_sr[MIX_LATENCY-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Every word in flight already owns a FIFO slot, so a push can never find it full.
  assign credit_used = SW'(inflight) + SW'(fifo_count) - SW'(pop);
  assign credit_ok   = (credit_used < SW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= ST_UNSEEDED;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    issue     = 1'b0;
    flush     = 1'b0;
    seed_take = 1'b0;
    pend_take = 1'b0;
    unique case (fsm_q)
      ST_UNSEEDED: begin
        if (seed_load) begin
          seed_take = 1'b1;
          fsm_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = gen_en && credit_ok;
        if (seed_load) begin
          pend_take = 1'b1;
          fsm_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight == '0) begin
          flush = 1'b1;
          fsm_d = ST_RUN;
        end
      end
      default: fsm_d = ST_UNSEEDED;
    endcase
  end

  assign seed_busy = (fsm_q == ST_DRAIN);
  assign fsm_state = fsm_q;
  assign mix_in    = mix_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
      mix_q  <= '0;
      pend_q <= '0;
    end else begin
      if (seed_take) begin
        lane_q <= seed_in;
      end else if (flush) begin
        lane_q <= pend_q;
      end else if (issue) begin
        lane_q <= lane_next;
      end
      if (issue) begin
        mix_q <= lane_next;
      end
      if (pend_take) begin
        pend_q <= seed_in;
      end
    end
  end

  // One bit per issued word, aligned so the top bit meets the matching mix_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < MIX_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= mix_out;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef SPLITMIX256_CTRL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_count <= '0;
    end else if (flush) begin
      gen_count <= '0;
    end else if (pop) begin
      gen_count <= gen_count + 64'd1;
    end
  end
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule
